// File: rtl/node_rec_rr_arbiter.sv
// Round-robin arbiter that grants one CAN bus receive flag at a time to the shared receive read path.
// Optional grant watchdog is built only when NODE_REC_TIMEOUT_EN is defined.
module node_rec_rr_arbiter #(
  parameter int N_BUS       = 32,
  parameter int ID_W        = 5,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BUS-1:0] can_rec,
  input  logic             enable,
  input  logic             rec_ack,
  output logic [N_BUS-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_valid,
  output logic             grant_abort,
  output logic [CNT_W-1:0] grant_cnt,
  output logic             timeout
);

  if ((2 ** ID_W) < N_BUS) begin : g_bad_id_w
    $error("node_rec_rr_arbiter: ID_W is too narrow to index N_BUS requesters");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("node_rec_rr_arbiter: TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_BUS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic             grant_valid_q, grant_valid_d;
  logic             grant_abort_q, grant_abort_d;
  logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;
  logic             timeout_q, timeout_d;

  logic [ID_W-1:0]  sel_id;
  logic             sel_found;
  logic [ID_W-1:0]  ptr_adv;
  logic             wd_expired;
  logic             withdrawn;

  // Rotating priority search: scanning offsets high-to-low leaves the
  // closest requester at or after ptr as the final winner.
  always_comb begin
    logic [ID_W-1:0] idx;
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    idx       = '0;
    sel_id    = '0;
    sel_found = 1'b0;
    for (int i = N_BUS - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr_q) + i) % N_BUS);
      if (can_rec[idx]) begin
        sel_id    = idx;
        sel_found = 1'b1;
      end
    end
  end

  assign ptr_adv   = (grant_id_q == ID_W'(N_BUS - 1)) ? '0 : grant_id_q + ID_W'(1);
  assign withdrawn = ~can_rec[grant_id_q];

`ifdef NODE_REC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);

  logic [WD_W-1:0] wd_q;

  assign wd_expired = (state_q == ST_GRANT) && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  // Held at zero outside GRANT, so it is already clear on GRANT entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else if (state_q != ST_GRANT) begin
      wd_q <= '0;
    end else if (!wd_expired) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    grant_abort_d = 1'b0;
    grant_cnt_d   = grant_cnt_q;
    timeout_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && sel_found) begin
          state_d       = ST_GRANT;
          grant_d       = N_BUS'(1) << sel_id;
          grant_id_d    = sel_id;
          grant_valid_d = 1'b1;
        end
      end

      ST_GRANT: begin
        // Ack wins over a same-cycle withdrawal; either wins over the watchdog.
        if (rec_ack) begin
          grant_cnt_d = grant_cnt_q + CNT_W'(1);
        end else if (withdrawn) begin
          grant_abort_d = 1'b1;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
        end

        if (rec_ack || withdrawn || wd_expired) begin
          state_d       = ST_RELEASE;
          ptr_d         = ptr_adv;
          grant_d       = '0;
          grant_valid_d = 1'b0;
        end
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d       = ST_IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      grant_abort_q <= 1'b0;
      grant_cnt_q   <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      grant_abort_q <= grant_abort_d;
      grant_cnt_q   <= grant_cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign grant_abort = grant_abort_q;
  assign grant_cnt   = grant_cnt_q;
  assign timeout     = timeout_q;

endmodule
